// File: rtl/cpu_pkg.sv
// cpu_pkg: shared op codes, write-back mux selects, widths and stage states for the CPU pipeline.
package cpu_pkg;
    localparam int DATA_W = 16;
    localparam int REG_SEL_W = 3;
    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_ALU   = 3'd1,
        OP_LOAD  = 3'd2,
        OP_STORE = 3'd3,
        OP_LINK  = 3'd4
    } op_e;
    localparam logic [1:0] SEL_ULA = 2'b00;
    localparam logic [1:0] SEL_MD  = 2'b01;
    localparam logic [1:0] SEL_PC  = 2'b10;
    typedef enum logic [1:0] {IDLE, MEM_WAIT, WB} state_e;
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: data-memory req/ack bus between the write-back stage and memory.
interface mem_wb_stage_if #(parameter int DATA_W = cpu_pkg::DATA_W);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
    modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_timeout_counter.sv
// mem_timeout_counter: saturating wait counter; tc flags the enabled cycle that brings it to MAX.
module mem_timeout_counter #(
    parameter int MAX = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = $clog2(MAX + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && cnt != W'(MAX)) cnt <= cnt + 1'b1;
    end
    assign tc = en && (cnt == W'(MAX - 1));
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: retires EX instructions, runs loads/stores over req/ack, and drives the register-bank write port.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_SEL_W = cpu_pkg::REG_SEL_W,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [DATA_W-1:0]    in_alu_result,
    input  logic [DATA_W-1:0]    in_store_data,
    input  logic [REG_SEL_W-1:0] in_dest,
    mem_wb_stage_if.master       mem,
    output logic                 wb_hab_escrita,
    output logic [REG_SEL_W-1:0] wb_sel_e,
    output logic [1:0]           wb_mux_sel,
    output logic [DATA_W-1:0]    wb_ula,
    output logic [DATA_W-1:0]    wb_md,
    output logic                 stall,
    output logic                 mem_err
);
    state_e state;
    logic [REG_SEL_W-1:0] dest;
    logic tc;
    mem_timeout_counter #(.MAX(MEM_TIMEOUT)) u_cnt (
        .clock(clock),
        .reset_n(reset_n),
        .clr(state != MEM_WAIT),
        .en(state == MEM_WAIT && !mem.mem_ack),
        .tc(tc)
    );
    assign in_ready = (state == IDLE);
    assign stall = in_valid && !in_ready;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            dest <= '0;
            mem.mem_req <= 1'b0;
            mem.mem_we <= 1'b0;
            mem.mem_addr <= '0;
            mem.mem_wdata <= '0;
            wb_hab_escrita <= 1'b0;
            wb_sel_e <= '0;
            wb_mux_sel <= SEL_ULA;
            wb_ula <= '0;
            wb_md <= '0;
            mem_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    case (in_op)
                        OP_ALU, OP_LINK: begin
                            wb_hab_escrita <= 1'b1;
                            wb_sel_e <= in_dest;
                            wb_ula <= in_alu_result;
                            wb_mux_sel <= (in_op == OP_LINK) ? SEL_PC : SEL_ULA;
                            state <= WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            mem.mem_req <= 1'b1;
                            mem.mem_we <= (in_op == OP_STORE);
                            mem.mem_addr <= in_alu_result;
                            mem.mem_wdata <= in_store_data;
                            dest <= in_dest;
                            state <= MEM_WAIT;
                        end
                        default: ;
                    endcase
                end
                MEM_WAIT: if (mem.mem_ack) begin
                    mem.mem_req <= 1'b0;
                    if (!mem.mem_we) begin
                        wb_md <= mem.mem_rdata;
                        wb_hab_escrita <= 1'b1;
                        wb_sel_e <= dest;
                        wb_mux_sel <= SEL_MD;
                    end
                    state <= mem.mem_we ? IDLE : WB;
                end else if (tc) begin
                    mem.mem_req <= 1'b0;
                    mem_err <= 1'b1;
                    state <= IDLE;
                end
                WB: begin
                    wb_hab_escrita <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed checks of ALU/LINK write-back, load/store handshakes, timeout and async reset.
module tb_mem_wb_stage;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [15:0] in_alu_result = '0;
    logic [15:0] in_store_data = '0;
    logic [2:0]  in_dest = '0;
    logic        wb_hab_escrita;
    logic [2:0]  wb_sel_e;
    logic [1:0]  wb_mux_sel;
    logic [15:0] wb_ula;
    logic [15:0] wb_md;
    logic        stall;
    logic        mem_err;
    int checks = 0;
    int errors = 0;
    int pulses;
    mem_wb_stage_if bus ();
    mem_wb_stage dut (
        .clock(clock),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_op(in_op),
        .in_alu_result(in_alu_result),
        .in_store_data(in_store_data),
        .in_dest(in_dest),
        .mem(bus.master),
        .wb_hab_escrita(wb_hab_escrita),
        .wb_sel_e(wb_sel_e),
        .wb_mux_sel(wb_mux_sel),
        .wb_ula(wb_ula),
        .wb_md(wb_md),
        .stall(stall),
        .mem_err(mem_err)
    );
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] res, input logic [15:0] sd, input logic [2:0] d);
        in_valid = 1'b1;
        in_op = op;
        in_alu_result = res;
        in_store_data = sd;
        in_dest = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        #12;
        chk("rst_ready", in_ready, 1);
        chk("rst_hab", wb_hab_escrita, 0);
        chk("rst_req", bus.mem_req, 0);
        chk("rst_err", mem_err, 0);
        chk("rst_ula", wb_ula, 0);
        step();
        reset_n = 1'b1;
        step();
        // ALU op: pulse in the cycle after acceptance, ready one cycle later
        issue(3'd1, 16'h1234, 16'h0, 3'd3);
        chk("alu_hab", wb_hab_escrita, 1);
        chk("alu_sel", wb_sel_e, 3);
        chk("alu_mux", wb_mux_sel, 0);
        chk("alu_ula", wb_ula, 16'h1234);
        chk("alu_ready_n1", in_ready, 0);
        step();
        chk("alu_hab_off", wb_hab_escrita, 0);
        chk("alu_ready_n2", in_ready, 1);
        chk("alu_ula_hold", wb_ula, 16'h1234);
        // LOAD acked in third wait cycle
        issue(3'd2, 16'h0040, 16'h0, 3'd5);
        chk("ld_req1", bus.mem_req, 1);
        chk("ld_we", bus.mem_we, 0);
        chk("ld_addr", bus.mem_addr, 16'h0040);
        chk("ld_ready", in_ready, 0);
        in_valid = 1'b1;
        in_op = 3'd1;
        #1;
        chk("ld_stall", stall, 1);
        in_valid = 1'b0;
        step();
        chk("ld_req2", bus.mem_req, 1);
        chk("ld_hab_wait", wb_hab_escrita, 0);
        step();
        chk("ld_req3", bus.mem_req, 1);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 16'hBEEF;
        step();
        bus.mem_ack = 1'b0;
        chk("ld_req_off", bus.mem_req, 0);
        chk("ld_hab", wb_hab_escrita, 1);
        chk("ld_md", wb_md, 16'hBEEF);
        chk("ld_mux", wb_mux_sel, 1);
        chk("ld_sel", wb_sel_e, 5);
        step();
        chk("ld_hab_off", wb_hab_escrita, 0);
        chk("ld_ready_after", in_ready, 1);
        // STORE with immediate ack
        issue(3'd3, 16'h0010, 16'hA5A5, 3'd2);
        chk("st_req", bus.mem_req, 1);
        chk("st_we", bus.mem_we, 1);
        chk("st_addr", bus.mem_addr, 16'h0010);
        chk("st_wdata", bus.mem_wdata, 16'hA5A5);
        bus.mem_ack = 1'b1;
        step();
        chk("st_req_off", bus.mem_req, 0);
        chk("st_hab", wb_hab_escrita, 0);
        chk("st_ready", in_ready, 1);
        chk("st_sel_hold", wb_sel_e, 5);
        // ack while idle is ignored
        step();
        bus.mem_ack = 1'b0;
        chk("idle_ack_hab", wb_hab_escrita, 0);
        chk("idle_ack_req", bus.mem_req, 0);
        // LOAD that never gets acked
        issue(3'd2, 16'h0070, 16'h0, 3'd1);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("to_req%0d", i), bus.mem_req, 1);
            pulses += int'(wb_hab_escrita);
            step();
        end
        chk("to_req_off", bus.mem_req, 0);
        chk("to_err", mem_err, 1);
        chk("to_ready", in_ready, 1);
        chk("to_pulses", pulses + int'(wb_hab_escrita), 0);
        issue(3'd1, 16'h0055, 16'h0, 3'd0);
        chk("to_alu_hab", wb_hab_escrita, 1);
        chk("to_alu_sel0", wb_sel_e, 0);
        chk("to_err_sticky", mem_err, 1);
        step();
        // async reset in the middle of a wait, with a new request pending
        issue(3'd2, 16'h0020, 16'h0, 3'd4);
        step();
        in_valid = 1'b1;
        in_op = 3'd2;
        reset_n = 1'b0;
        #1;
        chk("ar_req", bus.mem_req, 0);
        chk("ar_err", mem_err, 0);
        chk("ar_sel", wb_sel_e, 0);
        chk("ar_md", wb_md, 0);
        chk("ar_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        reset_n = 1'b1;
        step();
        chk("ar_hab_after", wb_hab_escrita, 0);
        chk("ar_req_after", bus.mem_req, 0);
        chk("ar_ready_after", in_ready, 1);
        // ack on exactly the 15th wait cycle wins over the timeout
        issue(3'd2, 16'h0080, 16'h0, 3'd6);
        for (int i = 0; i < 14; i++) step();
        chk("late_req15", bus.mem_req, 1);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 16'h1357;
        step();
        bus.mem_ack = 1'b0;
        chk("late_hab", wb_hab_escrita, 1);
        chk("late_md", wb_md, 16'h1357);
        chk("late_sel", wb_sel_e, 6);
        chk("late_err", mem_err, 0);
        step();
        chk("late_hab_off", wb_hab_escrita, 0);
        // LINK
        issue(3'd4, 16'h0102, 16'h0, 3'd7);
        chk("lnk_hab", wb_hab_escrita, 1);
        chk("lnk_mux", wb_mux_sel, 2);
        chk("lnk_sel", wb_sel_e, 7);
        step();
        chk("lnk_hab_off", wb_hab_escrita, 0);
        // NOP and reserved opcodes change nothing
        issue(3'd6, 16'hFFFF, 16'h0, 3'd1);
        chk("nop_ready", in_ready, 1);
        chk("nop_ula", wb_ula, 16'h0102);
        chk("nop_hab", wb_hab_escrita, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
